// File: rtl/motor_ctl_pkg.sv
// Shared types and constants for the motor command scheduler.
// Holds the scheduler state enum, command byte bit positions, the speed
// code width and the default timing parameters.
package motor_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    BUMP_STOP,
    BACKUP,
    TURN
  } state_t;

  localparam int SPD_W = 5;

  // Command byte layout: side | enable | dir | speed[4:0]
  localparam int CMD_SIDE_BIT = 7;
  localparam int CMD_EN_BIT   = 6;
  localparam int CMD_DIR_BIT  = 5;
  localparam int CMD_SPD_MSB  = 4;

  localparam int unsigned WDOG_CYCLES_DEF   = 6_000_000;
  localparam int unsigned BACKUP_CYCLES_DEF = 3_000_000;
  localparam int unsigned TURN_CYCLES_DEF   = 2_400_000;
  localparam int unsigned RAMP_CYCLES_DEF   = 12_000;
  localparam logic [SPD_W-1:0] BACKUP_SPEED_DEF = 5'd12;

  // A disabled command always means "stop", whatever speed bits it carries.
  function automatic logic [SPD_W-1:0] cmd_target(input logic [7:0] cmd);
    return cmd[CMD_EN_BIT] ? cmd[CMD_SPD_MSB:0] : '0;
  endfunction

endpackage

// File: rtl/speed_ramp.sv
// Per-motor speed ramp.
// Moves the speed output one step toward the target on each tick. A
// direction change first ramps down to zero and flips direction on the tick
// that lands on zero, so direction never changes while moving.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           synchronous clear of speed, dir and enable
//   tick          ramp step strobe
//   target_speed  requested speed code
//   target_dir    requested direction (0 = forward)
//   target_en     requested enable
//   speed, dir, en  ramped outputs
import motor_ctl_pkg::*;

module speed_ramp (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [SPD_W-1:0] target_speed,
  input  logic             target_dir,
  input  logic             target_en,
  output logic [SPD_W-1:0] speed,
  output logic             dir,
  output logic             en
);

  logic [SPD_W-1:0] speed_nxt;
  logic             dir_nxt;

  always_comb begin
    speed_nxt = speed;
    dir_nxt   = dir;
    if (tick) begin
      if (dir != target_dir) begin
        if (speed != '0) speed_nxt = speed - 5'd1;
        if (speed <= 5'd1) dir_nxt = target_dir;
      end else if (speed < target_speed) begin
        speed_nxt = speed + 5'd1;
      end else if (speed > target_speed) begin
        speed_nxt = speed - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed <= '0;
      dir   <= 1'b0;
      en    <= 1'b0;
    end else if (clr) begin
      speed <= '0;
      dir   <= 1'b0;
      en    <= 1'b0;
    end else begin
      speed <= speed_nxt;
      dir   <= dir_nxt;
      // Enable drops on the same edge the speed lands on zero.
      en    <= target_en || (en && (speed_nxt != '0));
    end
  end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Two-motor command scheduler with watchdog and bump reflex.
// Decodes UART command bytes into per-side targets, ramps each motor via
// speed_ramp, stops everything on command silence, and runs a fixed
// stop / back-up / pivot reflex when a bump switch closes.
// Ports:
//   WF_CLK, WF_BUTTON        clock, async active-low reset
//   rx_data, rx_valid        command byte and its strobe
//   bump[5:0]                raw bump switches, [2:0] left, [5:3] right
//   motorL_*, motorR_*       enable, direction, speed per motor
//   reflex_active            high while the reflex sequence runs
//   wdog_stop                sticky watchdog-expired flag
//
// state     | meaning
// IDLE      | no motion, waiting for a command
// DRIVE     | following commanded targets through the ramps
// BUMP_STOP | one-cycle hard stop after a bump
// BACKUP    | both motors reverse at reflex speed
// TURN      | pivot away from the bumped side
import motor_ctl_pkg::*;

module motor_cmd_scheduler #(
  parameter int unsigned      WDOG_CYCLES   = WDOG_CYCLES_DEF,
  parameter int unsigned      BACKUP_CYCLES = BACKUP_CYCLES_DEF,
  parameter int unsigned      TURN_CYCLES   = TURN_CYCLES_DEF,
  parameter int unsigned      RAMP_CYCLES   = RAMP_CYCLES_DEF,
  parameter logic [SPD_W-1:0] BACKUP_SPEED  = BACKUP_SPEED_DEF
) (
  input  logic             WF_CLK,
  input  logic             WF_BUTTON,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [5:0]       bump,
  output logic             motorL_en,
  output logic             motorR_en,
  output logic             motorL_dir,
  output logic             motorR_dir,
  output logic [SPD_W-1:0] motorL_speed,
  output logic [SPD_W-1:0] motorR_speed,
  output logic             reflex_active,
  output logic             wdog_stop
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);
  localparam int TMR_MAX = (BACKUP_CYCLES > TURN_CYCLES) ? BACKUP_CYCLES : TURN_CYCLES;
  localparam int TMR_W  = $clog2(TMR_MAX + 1);

  state_t state, state_nxt;

  logic [5:0]       bump_s1, bump_s2;
  logic [WDOG_W-1:0] wcnt;
  logic [RAMP_W-1:0] rcnt;
  logic [TMR_W-1:0]  tcnt;
  logic             turn_left_fwd;

  logic [SPD_W-1:0] tgt_l_spd, tgt_r_spd;
  logic             tgt_l_dir, tgt_r_dir, tgt_l_en, tgt_r_en;
  logic [SPD_W-1:0] ramp_l_spd, ramp_r_spd;
  logic             ramp_l_dir, ramp_r_dir, ramp_l_en, ramp_r_en;

  logic cmd_phase, bump_any, bump_hit, accept, wdog_expire, ramp_clr, tick;

  assign cmd_phase   = (state == IDLE) || (state == DRIVE);
  assign bump_any    = |bump_s2;
  assign bump_hit    = cmd_phase && bump_any;
  assign accept      = cmd_phase && rx_valid && !bump_any;
  assign wdog_expire = (state == DRIVE) && (wcnt == '0) && !accept && !bump_hit;
  // Ramps and targets stay zero outside normal driving so the reflex
  // always hands back to IDLE from a clean stop.
  assign ramp_clr    = !cmd_phase || bump_hit || wdog_expire;
  assign tick        = (state == DRIVE) && (rcnt == '0);

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      state         <= IDLE;
      bump_s1       <= '0;
      bump_s2       <= '0;
      wcnt          <= WDOG_W'(WDOG_CYCLES - 1);
      rcnt          <= RAMP_W'(RAMP_CYCLES - 1);
      tcnt          <= TMR_W'(BACKUP_CYCLES - 1);
      turn_left_fwd <= 1'b0;
      wdog_stop     <= 1'b0;
      tgt_l_spd     <= '0;
      tgt_l_dir     <= 1'b0;
      tgt_l_en      <= 1'b0;
      tgt_r_spd     <= '0;
      tgt_r_dir     <= 1'b0;
      tgt_r_en      <= 1'b0;
    end else begin
      state   <= state_nxt;
      bump_s1 <= bump;
      bump_s2 <= bump_s1;

      if (accept || state != DRIVE) wcnt <= WDOG_W'(WDOG_CYCLES - 1);
      else if (wcnt != '0)          wcnt <= wcnt - 1'b1;

      if (state != DRIVE || rcnt == '0) rcnt <= RAMP_W'(RAMP_CYCLES - 1);
      else                              rcnt <= rcnt - 1'b1;

      case (state)
        BACKUP:  tcnt <= (tcnt == '0) ? TMR_W'(TURN_CYCLES - 1) : tcnt - 1'b1;
        TURN:    if (tcnt != '0) tcnt <= tcnt - 1'b1;
        default: tcnt <= TMR_W'(BACKUP_CYCLES - 1);
      endcase

      // Any left-side contact wins the pivot decision.
      if (bump_hit) turn_left_fwd <= |bump_s2[2:0];

      if (accept)           wdog_stop <= 1'b0;
      else if (wdog_expire) wdog_stop <= 1'b1;

      if (ramp_clr) begin
        tgt_l_spd <= '0;
        tgt_l_dir <= 1'b0;
        tgt_l_en  <= 1'b0;
        tgt_r_spd <= '0;
        tgt_r_dir <= 1'b0;
        tgt_r_en  <= 1'b0;
      end else if (accept) begin
        if (rx_data[CMD_SIDE_BIT]) begin
          tgt_r_spd <= cmd_target(rx_data);
          tgt_r_dir <= rx_data[CMD_DIR_BIT];
          tgt_r_en  <= rx_data[CMD_EN_BIT];
        end else begin
          tgt_l_spd <= cmd_target(rx_data);
          tgt_l_dir <= rx_data[CMD_DIR_BIT];
          tgt_l_en  <= rx_data[CMD_EN_BIT];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bump_hit) state_nxt = BUMP_STOP;
                 else if (accept) state_nxt = DRIVE;
      DRIVE:     if (bump_hit) state_nxt = BUMP_STOP;
                 else if (wdog_expire) state_nxt = IDLE;
      BUMP_STOP: state_nxt = BACKUP;
      BACKUP:    if (tcnt == '0) state_nxt = TURN;
      TURN:      if (tcnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    motorL_en     = ramp_l_en;
    motorR_en     = ramp_r_en;
    motorL_dir    = ramp_l_dir;
    motorR_dir    = ramp_r_dir;
    motorL_speed  = ramp_l_spd;
    motorR_speed  = ramp_r_spd;
    reflex_active = 1'b0;
    case (state)
      BUMP_STOP: begin
        motorL_en     = 1'b0;
        motorR_en     = 1'b0;
        motorL_dir    = 1'b0;
        motorR_dir    = 1'b0;
        motorL_speed  = '0;
        motorR_speed  = '0;
        reflex_active = 1'b1;
      end
      BACKUP: begin
        motorL_en     = 1'b1;
        motorR_en     = 1'b1;
        motorL_dir    = 1'b1;
        motorR_dir    = 1'b1;
        motorL_speed  = BACKUP_SPEED;
        motorR_speed  = BACKUP_SPEED;
        reflex_active = 1'b1;
      end
      TURN: begin
        motorL_en     = 1'b1;
        motorR_en     = 1'b1;
        motorL_dir    = !turn_left_fwd;
        motorR_dir    = turn_left_fwd;
        motorL_speed  = BACKUP_SPEED;
        motorR_speed  = BACKUP_SPEED;
        reflex_active = 1'b1;
      end
      default: ;
    endcase
  end

  speed_ramp u_ramp_l (
    .clk          (WF_CLK),
    .rst_n        (WF_BUTTON),
    .clr          (ramp_clr),
    .tick         (tick),
    .target_speed (tgt_l_spd),
    .target_dir   (tgt_l_dir),
    .target_en    (tgt_l_en),
    .speed        (ramp_l_spd),
    .dir          (ramp_l_dir),
    .en           (ramp_l_en)
  );

  speed_ramp u_ramp_r (
    .clk          (WF_CLK),
    .rst_n        (WF_BUTTON),
    .clr          (ramp_clr),
    .tick         (tick),
    .target_speed (tgt_r_spd),
    .target_dir   (tgt_r_dir),
    .target_en    (tgt_r_en),
    .speed        (ramp_r_spd),
    .dir          (ramp_r_dir),
    .en           (ramp_r_en)
  );

endmodule

// File: doc/motor_cmd_scheduler.md
MOTOR_CMD_SCHEDULER -- requirements
Module: motor_cmd_scheduler

Interface
REQ-001 Parameter WDOG_CYCLES, default 6_000_000, command-silence timeout in clocks (0.5 s at 12 MHz).
REQ-002 Parameter BACKUP_CYCLES, default 3_000_000, reverse duration of the bump reflex.
REQ-003 Parameter TURN_CYCLES, default 2_400_000, pivot duration of the bump reflex.
REQ-004 Parameter RAMP_CYCLES, default 12_000, clocks per one-step speed change.
REQ-005 Parameter BACKUP_SPEED, default 5'd12, reflex speed code.
REQ-006 WF_CLK  in  1  sole clock, all logic rising-edge.
REQ-007 WF_BUTTON  in  1  reset, asynchronous, active-low.
REQ-008 rx_data  in  8  command byte from the UART receiver.
REQ-009 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-010 bump  in  6  raw bump switches, 1 = pressed; [2:0] left side, [5:3] right side.
REQ-011 motorL_en, motorR_en  out  1 each  motor enable.
REQ-012 motorL_dir, motorR_dir  out  1 each  0 = forward, 1 = reverse.
REQ-013 motorL_speed, motorR_speed  out  5 each  speed setpoint to the speed controllers.
REQ-014 reflex_active  out  1  high in BUMP_STOP, BACKUP and TURN.
REQ-015 wdog_stop  out  1  sticky flag, set on watchdog expiry, cleared by the next accepted command.

Function
REQ-016 Command byte: bit7 side (0 = left, 1 = right), bit6 enable, bit5 dir, bits[4:0] target speed; enable = 0 forces target speed 0.
REQ-017 FSM states: IDLE, DRIVE, BUMP_STOP, BACKUP, TURN.
REQ-018 In IDLE or DRIVE, rx_valid latches the selected side's target on the next edge; the other side is unchanged; IDLE -> DRIVE.
REQ-019 Enable output rises the cycle after the target is latched with enable = 1; it falls only when that side's speed output reaches 0 with target enable = 0.
REQ-020 Each side ramps its speed output by exactly 1 toward target once per RAMP_CYCLES tick; no overshoot; 5-bit unsigned, no wrap.
REQ-021 Target dir differing from current dir: ramp down to 0, flip dir on the tick that reaches 0, then ramp up; dir never changes at non-zero speed.
REQ-022 Watchdog counter clears on every accepted rx_valid; reaching WDOG_CYCLES in DRIVE -> targets, speeds and enables zeroed in one cycle, wdog_stop = 1, -> IDLE.
REQ-023 Bumps pass a 2-flop synchronizer; any synchronized bump in IDLE or DRIVE -> BUMP_STOP.
REQ-024 BUMP_STOP lasts 1 cycle: both speeds 0, enables 0, ramp bypassed; -> BACKUP.
REQ-025 BACKUP: both en = 1, dir = 1, speed = BACKUP_SPEED for BACKUP_CYCLES; -> TURN.
REQ-026 TURN for TURN_CYCLES at BACKUP_SPEED: left-side bump -> left fwd, right rev; right-only bump -> left rev, right fwd; both sides -> left-side rule.
REQ-027 TURN end -> IDLE with targets, speeds and enables 0; ramp state restarts from 0.
REQ-028 During BUMP_STOP, BACKUP and TURN, rx_valid is discarded and further bumps are ignored; the watchdog is held cleared.
REQ-029 rx_valid and a synchronized bump in the same cycle: bump wins, byte discarded.

Reset
REQ-030 WF_BUTTON low immediately forces IDLE, all outputs 0, counters, targets and synchronizers 0, wdog_stop 0, including mid-reflex.
REQ-031 First accepted command is honoured on the first rx_valid after reset release.

Structure
REQ-032 Package motor_ctl_pkg holds the state enum, command bit-position constants and parameter defaults.
REQ-033 One sub-module speed_ramp (target, dir, tick -> speed, dir, en) is instantiated per motor; FSM, watchdog, tick generator and synchronizers stay in the top.

Verification (bench: WDOG = 100, BACKUP = 20, TURN = 10, RAMP = 4)
REQ-034 Release reset, send 0x4A -> motorL_en = 1 the cycle after latch; speed 0 -> 10 in 1 step per 4 clocks (10 at 40 clocks); right outputs stay 0.
REQ-035 Left at 10 fwd, send 0x65 -> ramps to 0, dir = 1 at the 0 tick, ramps to 5; dir never toggles at non-zero speed.
REQ-036 No command for 100 clocks in DRIVE -> all en/speed 0, wdog_stop = 1, IDLE; next 0xCA clears wdog_stop and drives right to 10.
REQ-037 bump[1] pulse in DRIVE -> BUMP_STOP after 2-cycle sync, then 20 clocks both rev at 12, then 10 clocks L fwd / R rev, then IDLE at zero; rx_valid 0x4A during BACKUP has no effect.
REQ-038 rx_valid 0x4A coincident with synchronized bump[4] -> reflex taken, byte dropped; TURN is L rev / R fwd.
REQ-039 WF_BUTTON low mid-BACKUP -> all outputs 0 within the same cycle, reflex_active 0; after release, state is IDLE.
